// File: rtl/fetch_stage.sv
// Front-end fetch stage: owns the PC, issues one word request per cycle to a
// synchronous instruction memory, and queues returned words toward Decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        valid_out,
  input  logic        ready_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [31:0]   fifo_instr_r [DEPTH];
  logic [31:0]   fifo_pc_r    [DEPTH];
  logic          inflight_r;
  logic          epoch_r;
  logic          tag_epoch_r;
  logic [31:0]   tag_pc_r;

  logic          pop_s;
  logic          push_s;
  logic          req_s;
  logic [CW:0]   credit_s;

  assign valid_out = (count_r != {CW{1'b0}}) && !redirect_valid;
  assign pop_s     = valid_out && ready_out;
  assign instr     = fifo_instr_r[head_r];
  assign pc_out    = fifo_pc_r[head_r];

  // An entry leaving this cycle frees its slot for the request issued now,
  // which keeps a DEPTH=2 queue streaming one word per cycle.
  assign credit_s  = {1'b0, count_r} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
  assign req_s     = reset && !redirect_valid && (credit_s < DEPTH_V);
  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_r;

  assign push_s = imem_rvalid && inflight_r && (tag_epoch_r == epoch_r) && !redirect_valid;

  // PC, credit, epoch tagging and FIFO state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r  <= RESET_PC;
      count_r     <= {CW{1'b0}};
      head_r      <= {AW{1'b0}};
      tail_r      <= {AW{1'b0}};
      inflight_r  <= 1'b0;
      epoch_r     <= 1'b0;
      tag_epoch_r <= 1'b0;
      tag_pc_r    <= 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_r[i] <= 32'h0000_0000;
        fifo_pc_r[i]    <= 32'h0000_0000;
      end
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
      count_r    <= {CW{1'b0}};
      head_r     <= {AW{1'b0}};
      tail_r     <= {AW{1'b0}};
      epoch_r    <= ~epoch_r;
      if (imem_rvalid) begin
        inflight_r <= 1'b0;
      end else begin
        inflight_r <= inflight_r;
      end
    end else begin
      if (req_s) begin
        fetch_pc_r  <= fetch_pc_r + 32'd4;
        tag_pc_r    <= fetch_pc_r;
        tag_epoch_r <= epoch_r;
        inflight_r  <= 1'b1;
      end else if (imem_rvalid) begin
        inflight_r  <= 1'b0;
      end else begin
        inflight_r  <= inflight_r;
      end
      if (push_s) begin
        fifo_instr_r[tail_r] <= imem_rdata;
        fifo_pc_r[tail_r]    <= tag_pc_r;
        tail_r               <= tail_r + AW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  fetch_stage_chk #(.DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .count (count_r)
  );

endmodule

// Simulation checks on FIFO occupancy; carries no functional logic.
module fetch_stage_chk #(
  parameter int DEPTH = 2
) (
  input logic                     clk,
  input logic                     reset,
  input logic                     push,
  input logic [$clog2(DEPTH):0]   count
);

  // A push into a full queue means the credit rule was broken
  always @(posedge clk) begin
    if (reset) begin
      assert (!(push && (int'(count) == DEPTH)));
      assert (int'(count) <= DEPTH);
    end
  end

endmodule
